// File: rtl/br_arb_pri_rr_burst.sv
// Prioritized round-robin burst arbiter: shares one valid/ready channel among
// NumRequesters burst sources. Highest effective priority wins, ties resolve
// round-robin, the grant is held until the owner's last beat is accepted, and
// saturating age counters lift starved requesters above every static level.
module br_arb_pri_rr_burst #(
  parameter int unsigned NumRequesters = 2,
  parameter int unsigned NumPriorities = 2,
  parameter int unsigned MaxAge        = 7,
  localparam int unsigned PriorityWidth = $clog2(NumPriorities)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NumRequesters-1:0]                     req_valid,
  input  logic [NumRequesters-1:0][PriorityWidth-1:0]  req_priority,
  input  logic [NumRequesters-1:0]                     req_last,
  output logic [NumRequesters-1:0]                     req_ready,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [NumRequesters-1:0]                     out_grant,
  output logic [PriorityWidth-1:0]                     out_priority,
  output logic                                         out_last
);

  localparam int unsigned IdxWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int unsigned AgeWidth = $clog2(MaxAge + 1);
  // One extra level above the static range is reserved for aged requesters.
  localparam int unsigned EffWidth = $clog2(NumPriorities + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                                 state_q, state_d;
  logic [IdxWidth-1:0]                    locked_idx_q, locked_idx_d;
  logic [IdxWidth-1:0]                    rr_last_q, rr_last_d;
  logic [NumRequesters-1:0][AgeWidth-1:0] age_q, age_d;

  logic [NumRequesters-1:0][EffWidth-1:0] eff_pri;
  logic [EffWidth-1:0]                    max_pri;
  logic                                   win_found;
  logic [IdxWidth-1:0]                    win_idx;
  logic [IdxWidth-1:0]                    owner;
  logic                                   accept_last;
  int unsigned                            scan_idx;

  // Effective priority per requester and the maximum among valid requesters.
  always_comb begin
    eff_pri = '0;
    max_pri = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      if (age_q[i] == AgeWidth'(MaxAge)) begin
        eff_pri[i] = EffWidth'(NumPriorities);
      end else begin
        eff_pri[i] = EffWidth'(req_priority[i]);
      end
      if (req_valid[i] && (eff_pri[i] > max_pri)) begin
        max_pri = eff_pri[i];
      end
    end
  end

  // Cyclic scan from rr_last+1 picks the first top-priority valid requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NumRequesters; k++) begin
      scan_idx = (32'(rr_last_q) + k) % NumRequesters;
      if (!win_found && req_valid[scan_idx] && (eff_pri[scan_idx] == max_pri)) begin
        win_found = 1'b1;
        win_idx   = IdxWidth'(scan_idx);
      end
    end
  end

  // Downstream channel and per-requester ready; everything quiet during reset.
  always_comb begin
    out_valid    = 1'b0;
    out_grant    = '0;
    req_ready    = '0;
    out_priority = '0;
    out_last     = 1'b0;
    owner        = win_idx;
    if (!rst) begin
      if (state_q == StLocked) begin
        owner     = locked_idx_q;
        out_valid = req_valid[locked_idx_q];
      end else begin
        out_valid = win_found;
      end
      if (out_valid) begin
        out_grant[owner] = 1'b1;
        req_ready[owner] = out_ready;
        out_priority     = req_priority[owner];
        out_last         = req_last[owner];
      end
    end
  end

  // Next state: commit arbitration in IDLE, hold the grant until the last beat.
  always_comb begin
    state_d      = state_q;
    locked_idx_d = locked_idx_q;
    rr_last_d    = rr_last_q;
    age_d        = age_q;
    accept_last  = out_valid && out_ready && out_last;
    case (state_q)
      StIdle: begin
        // The decision commits even if the beat stalls, so the grant stays stable.
        if (out_valid) begin
          rr_last_d = win_idx;
          for (int unsigned i = 0; i < NumRequesters; i++) begin
            if (IdxWidth'(i) == win_idx) begin
              age_d[i] = '0;
            end else if (req_valid[i]) begin
              if (age_q[i] != AgeWidth'(MaxAge)) begin
                age_d[i] = age_q[i] + AgeWidth'(1);
              end
            end else begin
              age_d[i] = '0;
            end
          end
          if (!accept_last) begin
            state_d      = StLocked;
            locked_idx_d = win_idx;
          end
        end
      end
      StLocked: begin
        if (accept_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      locked_idx_q <= '0;
      rr_last_q    <= IdxWidth'(NumRequesters - 1);
      age_q        <= '0;
    end else begin
      state_q      <= state_d;
      locked_idx_q <= locked_idx_d;
      rr_last_q    <= rr_last_d;
      age_q        <= age_d;
    end
  end

  // Requester obligations and output invariants.
  for (genvar g = 0; g < NumRequesters; g++) begin : g_req_checks
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[g] && !req_ready[g]) |=> ($stable(req_priority[g]) && $stable(req_last[g])));
    assert property (@(posedge clk) disable iff (rst)
      req_valid[g] |-> (32'(req_priority[g]) < NumPriorities));
  end

  assert property (@(posedge clk) $onehot0(out_grant));
  assert property (@(posedge clk) out_valid |-> $onehot(out_grant));
  assert property (@(posedge clk) (req_ready & ~out_grant) == '0);

endmodule

// File: tb/tb_br_arb_pri_rr_burst.sv
// Randomized bench for br_arb_pri_rr_burst with a behavioural scheduler model,
// plus short directed scenarios for round-robin, stall, lock, reset and aging.
module tb_br_arb_pri_rr_burst;

  localparam int NR = 4;
  localparam int NP = 4;
  localparam int MA = 3;
  localparam int PW = 2;

  logic                   clk;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][PW-1:0]  req_priority;
  logic [NR-1:0]          req_last;
  logic [NR-1:0]          req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [NR-1:0]          out_grant;
  logic [PW-1:0]          out_priority;
  logic                   out_last;

  br_arb_pri_rr_burst #(
    .NumRequesters(NR),
    .NumPriorities(NP),
    .MaxAge       (MA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_priority(req_priority),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_grant   (out_grant),
    .out_priority(out_priority),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Burst sources: active flag, beats remaining, priority held for the burst.
  int src_active[NR];
  int src_beats[NR];
  int src_prio[NR];

  // Reference model: owner of a locked burst (-1 when idle), rr pointer, ages.
  int m_owner;
  int m_rr;
  int m_age[NR];

  logic          smp_valid;
  logic [NR-1:0] smp_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = NR - 1;
    for (int i = 0; i < NR; i++) m_age[i] = 0;
  endtask

  // One clock cycle: drive sources, check at the falling edge, advance model.
  task automatic step(input logic rdy, input logic r);
    int            ep[NR];
    int            maxp;
    int            own;
    int            j;
    logic          ev;
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    logic [PW-1:0] epri;
    logic          el;
    rst       = r;
    out_ready = rdy;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]    = (src_active[i] != 0);
      req_priority[i] = PW'(src_prio[i]);
      req_last[i]     = (src_beats[i] == 1);
    end
    @(negedge clk);
    ev = 1'b0; eg = '0; er = '0; epri = '0; el = 1'b0; own = -1;
    if (!r) begin
      if (m_owner >= 0) begin
        if (src_active[m_owner] != 0) own = m_owner;
      end else begin
        maxp = -1;
        for (int i = 0; i < NR; i++) begin
          ep[i] = -1;
          if (src_active[i] != 0) begin
            ep[i] = (m_age[i] == MA) ? NP : src_prio[i];
            if (ep[i] > maxp) maxp = ep[i];
          end
        end
        for (int k = 1; k <= NR; k++) begin
          j = (m_rr + k) % NR;
          if (own < 0 && src_active[j] != 0 && ep[j] == maxp) own = j;
        end
      end
      if (own >= 0) begin
        ev       = 1'b1;
        eg[own]  = 1'b1;
        er[own]  = rdy;
        epri     = PW'(src_prio[own]);
        el       = (src_beats[own] == 1);
      end
    end
    check_eq("out_valid", 32'(out_valid), 32'(ev));
    check_eq("out_grant", 32'(out_grant), 32'(eg));
    check_eq("req_ready", 32'(req_ready), 32'(er));
    check_eq("out_priority", 32'(out_priority), 32'(epri));
    check_eq("out_last", 32'(out_last), 32'(el));
    smp_valid = out_valid;
    smp_grant = out_grant;
    if (r) begin
      model_reset();
    end else begin
      if (m_owner < 0 && ev) begin
        m_rr = own;
        for (int i = 0; i < NR; i++) begin
          if (i == own) m_age[i] = 0;
          else if (src_active[i] != 0) m_age[i] = (m_age[i] < MA) ? m_age[i] + 1 : MA;
          else m_age[i] = 0;
        end
        m_owner = (rdy && el) ? -1 : own;
      end else if (m_owner >= 0 && ev && rdy && el) begin
        m_owner = -1;
      end
      if (ev && rdy) begin
        src_beats[own]--;
        if (src_beats[own] == 0) src_active[own] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int idx, input int prio, input int beats);
    src_active[idx] = 1;
    src_prio[idx]   = prio;
    src_beats[idx]  = beats;
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    rst = 1'b1; out_ready = 1'b0; req_valid = '0; req_priority = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin
      src_active[i] = 0; src_beats[i] = 0; src_prio[i] = 0;
    end
    model_reset();
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with requests pending.
    raise(1, 2, 2);
    step(1'b1, 1'b1);
    check_eq("rst_valid", 32'(smp_valid), 32'd0);
    check_eq("rst_grant", 32'(smp_grant), 32'd0);
    src_active[1] = 0; src_beats[1] = 0;

    // Round-robin among equal single-beat requesters: 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NR; i++) raise(i, 1, 1);
      step(1'b1, 1'b0);
      exp_g = '0;
      exp_g[c % NR] = 1'b1;
      check_eq("rr_grant", 32'(smp_grant), 32'(exp_g));
    end
    for (int i = 0; i < NR; i++) begin
      src_active[i] = 0; src_beats[i] = 0;
    end
    step(1'b0, 1'b1);

    // Downstream stall: requester 0 keeps the grant while requester 1 waits.
    raise(0, 0, 1);
    step(1'b0, 1'b0);
    check_eq("stall_grant", 32'(smp_grant), 32'h1);
    raise(1, 3, 1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0);
      check_eq("stall_grant", 32'(smp_grant), 32'h1);
    end
    step(1'b1, 1'b0);
    check_eq("stall_accept", 32'(smp_grant), 32'h1);
    step(1'b1, 1'b0);
    check_eq("stall_next", 32'(smp_grant), 32'h2);
    step(1'b0, 1'b1);

    // Burst lock: 4-beat burst from requester 1 is not preempted by requester 3.
    raise(1, 0, 4);
    step(1'b1, 1'b0);
    check_eq("lock_grant", 32'(smp_grant), 32'h2);
    raise(3, 3, 1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0);
      check_eq("lock_grant", 32'(smp_grant), 32'h2);
    end
    step(1'b1, 1'b0);
    check_eq("lock_after", 32'(smp_grant), 32'h8);

    // Reset mid-burst, then requester 0 wins a tie against requester 2.
    raise(1, 0, 3);
    step(1'b1, 1'b0);
    check_eq("midrst_beat1", 32'(smp_grant), 32'h2);
    raise(0, 3, 1);
    raise(2, 3, 1);
    step(1'b1, 1'b1);
    check_eq("midrst_valid", 32'(smp_valid), 32'd0);
    step(1'b1, 1'b0);
    check_eq("midrst_tie", 32'(smp_grant), 32'h1);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Aged tie: two starved low-priority requesters resolve round-robin.
    for (int c = 0; c < 5; c++) begin
      if (src_active[0] == 0) raise(0, 0, 1);
      if (src_active[1] == 0) raise(1, 0, 1);
      if (src_active[3] == 0) raise(3, 3, 1);
      step(1'b1, 1'b0);
      exp_g = (c < 3) ? 4'h8 : ((c == 3) ? 4'h1 : 4'h2);
      check_eq("aged_grant", 32'(smp_grant), 32'(exp_g));
    end
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_active[i] == 0 && $urandom_range(0, 2) == 0) begin
          raise(i, int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 4)));
        end
      end
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
